// File: rtl/noc_flit_injector_if.sv
// noc_flit_injector_if: descriptor, payload-word and FIFO write-port signals of the flit injector
// master: core/FIFO side (drives descriptors, words, fifo_full)
// slave : injector side (drives ready flags and the FIFO write port)
interface noc_flit_injector_if #(
    parameter int DSIZE  = 10,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 3
);
    logic              pkt_valid;
    logic              pkt_ready;
    logic [ADDR_W-1:0] pkt_dest;
    logic [LEN_W-1:0]  pkt_len;
    logic              word_valid;
    logic              word_ready;
    logic [DSIZE-3:0]  word_data;
    logic              fifo_full;
    logic              fifo_write;
    logic [DSIZE-1:0]  fifo_item;
    modport master (
        output pkt_valid, pkt_dest, pkt_len, word_valid, word_data, fifo_full,
        input  pkt_ready, word_ready, fifo_write, fifo_item
    );
    modport slave (
        input  pkt_valid, pkt_dest, pkt_len, word_valid, word_data, fifo_full,
        output pkt_ready, word_ready, fifo_write, fifo_item
    );
endinterface

// File: rtl/noc_flit_injector.sv
// noc_flit_injector: segments descriptor + payload words into head/body/tail flits for the FIFO write port
// wclkn, reset (sync, active-high); bus: noc_flit_injector_if.slave (descriptor, words, FIFO write port)
// busy: not IDLE; stat_pkts/stat_stall: counters built only with NOC_INJ_STATS_EN, else tied to 0
module noc_flit_injector #(
    parameter int DSIZE  = 10,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 3
) (
    input  logic                 wclkn,
    input  logic                 reset,
    noc_flit_injector_if.slave   bus,
    output logic                 busy,
    output logic [15:0]          stat_pkts,
    output logic [15:0]          stat_stall
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEAD    = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    logic [1:0]        state;
    logic [ADDR_W-1:0] dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem;
    logic              in_head;
    logic              in_pay;
    logic              last;
    logic [DSIZE-3:0]  head_pl;
    always_comb begin
        in_head        = !reset && state == HEAD;
        in_pay         = !reset && state == PAYLOAD;
        last           = in_head ? len_q == '0 : rem == LEN_W'(1);
        head_pl        = (DSIZE-2)'({len_q, dest_q});
        bus.pkt_ready  = !reset && state == IDLE;
        bus.word_ready = in_pay && !bus.fifo_full;
        // combinational so the FIFO's current full flag blocks the write on this edge
        bus.fifo_write = !bus.fifo_full && (in_head || (in_pay && bus.word_valid));
        bus.fifo_item  = in_head ? {last ? 2'b11 : 2'b01, head_pl}
                                 : {last ? 2'b10 : 2'b00, bus.word_data};
        busy           = in_head || in_pay;
    end
    always_ff @(posedge wclkn) begin
        if (reset) begin
            state  <= IDLE;
            dest_q <= '0;
            len_q  <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.pkt_valid) begin
                    state  <= HEAD;
                    dest_q <= bus.pkt_dest;
                    len_q  <= bus.pkt_len;
                end
                HEAD: if (bus.fifo_write) begin
                    state <= last ? IDLE : PAYLOAD;
                    rem   <= len_q;
                end
                PAYLOAD: if (bus.fifo_write) begin
                    state <= last ? IDLE : PAYLOAD;
                    rem   <= rem - LEN_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef NOC_INJ_STATS_EN
    // a stall is a cycle with a flit ready to go but held back by fifo_full
    logic stall;
    always_comb stall = bus.fifo_full && (in_head || (in_pay && bus.word_valid));
    always_ff @(posedge wclkn) begin
        if (reset) begin
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else begin
            stat_pkts  <= stat_pkts + 16'(bus.fifo_write && last);
            stat_stall <= stat_stall + 16'(stall);
        end
    end
`else
    assign stat_pkts  = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_noc_flit_injector.sv
// tb_noc_flit_injector: table-driven directed check of noc_flit_injector plus a HEAD-stall sequence
module tb_noc_flit_injector;
    logic        wclkn;
    logic        reset;
    logic        busy;
    logic [15:0] stat_pkts;
    logic [15:0] stat_stall;
    noc_flit_injector_if #(.DSIZE(10), .ADDR_W(4), .LEN_W(3)) bus ();
    noc_flit_injector #(.DSIZE(10), .ADDR_W(4), .LEN_W(3)) dut (
        .wclkn(wclkn), .reset(reset), .bus(bus),
        .busy(busy), .stat_pkts(stat_pkts), .stat_stall(stat_stall)
    );
    initial wclkn = 1'b0;
    always #5 wclkn = ~wclkn;
    typedef struct {
        logic       rst, pv;
        logic [3:0] d;
        logic [2:0] l;
        logic       wv;
        logic [7:0] wd;
        logic       ff;
        logic       pr, wr, we;
        logic [9:0] it;
        logic       bs, ci, cs;
        logic [15:0] pk, st;
    } vec_t;
    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int row   = 0;
    task automatic add(input logic rst, pv, input logic [3:0] d, input logic [2:0] l,
                       input logic wv, input logic [7:0] wd, input logic ff,
                       input logic pr, wr, we, input logic [9:0] it, input logic bs, ci);
        vec_t v;
        v = '{rst, pv, d, l, wv, wd, ff, pr, wr, we, it, bs, ci, 1'b0, 16'd0, 16'd0};
        tbl.push_back(v);
    endtask
    task automatic stat(input logic [15:0] pk, st);
        vec_t v;
        v = tbl.pop_back();
        v.cs = 1'b1;
        v.pk = pk;
        v.st = st;
        tbl.push_back(v);
    endtask
    task automatic drive(input logic rst, pv, input logic [3:0] d, input logic [2:0] l,
                         input logic wv, input logic [7:0] wd, input logic ff);
        @(negedge wclkn);
        reset          = rst;
        bus.pkt_valid  = pv;
        bus.pkt_dest   = d;
        bus.pkt_len    = l;
        bus.word_valid = wv;
        bus.word_data  = wd;
        bus.fifo_full  = ff;
        #1;
        if (bus.fifo_write) n_wr++;
    endtask
    task automatic cmp(input string nm, input logic [15:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask
    task automatic cmp_stats(input logic [15:0] pk, st);
`ifdef NOC_INJ_STATS_EN
        cmp("stat_pkts", stat_pkts, pk);
        cmp("stat_stall", stat_stall, st);
`else
        cmp("stat_pkts", stat_pkts, 16'd0 & pk);
        cmp("stat_stall", stat_stall, 16'd0 & st);
`endif
    endtask
    initial begin
        reset = 1'b1;
        bus.pkt_valid = 0; bus.pkt_dest = 0; bus.pkt_len = 0;
        bus.word_valid = 0; bus.word_data = 0; bus.fifo_full = 0;
        add(1,1,5,0,1,8'h00,0, 0,0,0,10'h000,0,0);
        add(1,0,0,0,0,8'h00,0, 0,0,0,10'h000,0,0);
        add(0,1,5,0,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,0,8'h00,0, 0,0,1,10'h305,1,1);
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(1,0);
        add(0,1,3,3,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,1,8'hA1,0, 0,0,1,10'h133,1,1);
        add(0,0,0,0,1,8'hA1,0, 0,1,1,10'h0A1,1,1);
        add(0,0,0,0,1,8'hB2,0, 0,1,1,10'h0B2,1,1);
        add(0,0,0,0,1,8'hC3,0, 0,1,1,10'h2C3,1,1);
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(2,0);
        add(0,1,3,3,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,1,8'hA1,0, 0,0,1,10'h133,1,1);
        add(0,0,0,0,1,8'hA1,0, 0,1,1,10'h0A1,1,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,1,8'hB2,1, 0,0,0,10'h0B2,1,1);
        add(0,0,0,0,1,8'hB2,0, 0,1,1,10'h0B2,1,1);
        add(0,0,0,0,1,8'hC3,0, 0,1,1,10'h2C3,1,1);
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(3,3);
        add(0,1,4'hA,7,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,0,8'h00,0, 0,0,1,10'h17A,1,1);
        for (int k = 1; k <= 7; k++) begin
            add(0,0,0,0,0,8'h00,0, 0,1,0,10'h000,1,0);
            add(0,0,0,0,1,8'(k),0, 0,1,1,{(k == 7) ? 2'b10 : 2'b00, 8'(k)},1,1);
        end
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(4,3);
        add(0,1,2,4,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,1,8'h11,0, 0,0,1,10'h142,1,1);
        add(0,0,0,0,1,8'h11,0, 0,1,1,10'h011,1,1);
        add(0,0,0,0,1,8'h22,0, 0,1,1,10'h022,1,1);
        add(1,1,0,0,1,8'h33,0, 0,0,0,10'h000,0,0);
        add(0,0,0,0,1,8'h33,0, 1,0,0,10'h000,0,0); stat(0,0);
        add(0,1,1,1,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,0,0,0,1,8'h55,0, 0,0,1,10'h111,1,1);
        add(0,0,0,0,1,8'h55,0, 0,1,1,10'h255,1,1);
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(1,0);
        add(0,1,4,1,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,1,6,0,1,8'h66,0, 0,0,1,10'h114,1,1);
        add(0,1,6,0,1,8'h66,0, 0,1,1,10'h266,1,1);
        add(0,1,6,0,0,8'h00,0, 1,0,0,10'h000,0,0);
        add(0,1,6,0,0,8'h00,0, 0,0,1,10'h306,1,1);
        add(0,0,0,0,0,8'h00,0, 1,0,0,10'h000,0,0); stat(3,0);
        foreach (tbl[i]) begin
            row = i;
            drive(tbl[i].rst, tbl[i].pv, tbl[i].d, tbl[i].l, tbl[i].wv, tbl[i].wd, tbl[i].ff);
            cmp("pkt_ready", 16'(bus.pkt_ready), 16'(tbl[i].pr));
            cmp("word_ready", 16'(bus.word_ready), 16'(tbl[i].wr));
            cmp("fifo_write", 16'(bus.fifo_write), 16'(tbl[i].we));
            cmp("busy", 16'(busy), 16'(tbl[i].bs));
            if (tbl[i].ci) cmp("fifo_item", 16'(bus.fifo_item), 16'(tbl[i].it));
            if (tbl[i].cs) cmp_stats(tbl[i].pk, tbl[i].st);
        end
        row = tbl.size();
        cmp("table_writes", 16'(n_wr), 16'd25);
        drive(1,0,0,0,0,8'h00,0);
        cmp("rst_busy", 16'(busy), 16'd0);
        drive(0,1,9,2,0,8'h00,1);
        cmp("acc_while_full", 16'(bus.pkt_ready), 16'd1);
        for (int i = 0; i < 4; i++) begin
            row++;
            drive(0,0,0,0,0,8'h00,1);
            cmp("head_hold_write", 16'(bus.fifo_write), 16'd0);
            cmp("head_hold_item", 16'(bus.fifo_item), 16'h129);
            cmp("head_hold_busy", 16'(busy), 16'd1);
        end
        drive(0,0,0,0,0,8'h00,0);
        cmp("head_release", 16'({bus.fifo_write, bus.fifo_item}), 16'h529);
        drive(0,0,0,0,0,8'h00,1);
        cmp("pay_full_ready", 16'({bus.word_ready, bus.fifo_write}), 16'd0);
        drive(0,0,0,0,1,8'h0F,0);
        cmp("body", 16'({bus.word_ready, bus.fifo_write, bus.fifo_item}), 16'hC0F);
        drive(0,0,0,0,1,8'hF0,0);
        cmp("tail", 16'({bus.word_ready, bus.fifo_write, bus.fifo_item}), 16'hEF0);
        drive(0,0,0,0,0,8'h00,0);
        cmp("idle_after", 16'({busy, bus.pkt_ready}), 16'd1);
        cmp_stats(16'd1, 16'd4);
        cmp("total_writes", 16'(n_wr), 16'd28);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
Upstream write-side stage for the dual-clock flit FIFO. It accepts a packet descriptor (destination, payload length) and a stream of payload words from the local core. It segments them into typed flits (head / body / tail) and pushes them into the FIFO write port, never writing while the FIFO reports full. It runs entirely in the FIFO's write-clock domain.

Parameters:
DSIZE, 10, flit width; must equal the FIFO data width; flit = {type[1:0], payload[DSIZE-3:0]}
ADDR_W, 4, destination router id width
LEN_W, 3, payload-length field width; max payload words = 2^LEN_W-1; ADDR_W+LEN_W <= DSIZE-2 required

Ports:
wclkn  input  1  write clock; all state updates on its rising edge
reset  input  1  synchronous, active-high
pkt_valid  input  1  descriptor valid
pkt_ready  output  1  descriptor accepted this cycle when pkt_valid&pkt_ready
pkt_dest  input  ADDR_W  destination id
pkt_len  input  LEN_W  number of payload words (0 allowed)
word_valid  input  1  payload word valid
word_ready  output  1  payload word consumed when word_valid&word_ready
word_data  input  DSIZE-2  payload word
fifo_full  input  1  FIFO full flag
fifo_write  output  1  FIFO write strobe (combinational)
fifo_item  output  DSIZE  flit to FIFO (combinational)
busy  output  1  high in any state other than IDLE
stat_pkts  output  16  packets completed (optional feature)
stat_stall  output  16  cycles a flit was pending while fifo_full=1 (optional feature)

Behaviour:
- Reset: clock wclkn; reset is synchronous, active-high. Reset forces state=IDLE and clears the latched dest, len and remaining count. While reset=1: pkt_ready=0, word_ready=0, fifo_write=0, busy=0.
- Flit types: 01=head, 00=body, 10=tail, 11=head+tail (single-flit packet).
- Head payload: {zero pad, len[LEN_W-1:0], dest[ADDR_W-1:0]}, right-justified.
- IDLE: pkt_ready=1. On pkt_valid, latch dest and len, then go to HEAD. No flit is written in the acceptance cycle.
- HEAD: fifo_item = head flit; fifo_write = !fifo_full.
  - Type is 11 if len==0, otherwise 01.
  - On a write: if len==0, go to IDLE. Otherwise remaining<=len and go to PAYLOAD.
  - If fifo_full=1, hold HEAD with fifo_item stable.
- PAYLOAD: word_ready = !fifo_full; fifo_write = word_valid & !fifo_full; fifo_item = {type, word_data}.
  - Type is 10 when remaining==1, otherwise 00.
  - Each write decrements remaining. The write with remaining==1 returns the FSM to IDLE.
  - word_ready is never asserted outside PAYLOAD.
- fifo_write is never 1 while fifo_full=1. The path is combinational so the FIFO sees the current full flag on the same wclkn edge.
- Latency: descriptor accepted at edge N → head written at edge N+1 at the earliest → payload word k written at the earliest at N+1+k.
- One IDLE bubble separates consecutive packets. Total flits per packet = 1+len.
- Descriptor inputs are ignored outside IDLE. pkt_valid may be held high without a duplicate accept.
- Reset mid-packet abandons the partial packet and returns to IDLE. The FIFO shares reset, so no orphan flits remain.
- pkt_len = 2^LEN_W-1 is legal; remaining never wraps.

Optional Feature:
NOC_INJ_STATS_EN
- Defined:
  - stat_pkts increments on every write of a tail flit or head+tail flit.
  - stat_stall increments on every cycle in HEAD, or in PAYLOAD with word_valid=1, while fifo_full=1.
  - Both counters are 16-bit, wrap modulo 2^16, and are cleared by reset.
- Undefined: stat_pkts and stat_stall are tied to 0 and no counter flops are built.

Test Plan:
1. Reset, then pkt_dest=5, pkt_len=0, fifo_full=0 → one write, fifo_item=10'b11_0000_0101; then IDLE; stat_pkts=1.
2. pkt_dest=3, len=3, words 0xA1,0xB2,0xC3 back-to-back → flits 01_00110011, 00_10100001, 00_10110010, 10_11000011 on 4 consecutive edges.
3. Same as test 2 with fifo_full=1 for 3 cycles during the 2nd body flit → fifo_write=0 and word_ready=0 while full; flit order unchanged; stat_stall=3.
4. len=7, word_valid toggling every other cycle → exactly 8 writes, tail on the 7th word, busy deasserts the next cycle.
5. Reset asserted after 2 of 4 body flits → next cycle IDLE, fifo_write=0; a following packet (dest=1, len=1) emits a correct head followed by a tail.
6. Two packets offered back-to-back with pkt_valid held high → second descriptor accepted only in the IDLE cycle after the first tail; no duplicate accept.
